// File: rtl/end_accumulator_pkg.sv
// Shared defaults and FSM state encoding for the multi-lane end accumulator.
package end_accumulator_pkg;

    localparam int unsigned DefDwidth = 32;
    localparam int unsigned DefLanes  = 4;
    localparam int unsigned DefLenW   = 8;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StAcc  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/end_acc_lane.sv
// One accumulation lane: wide accumulator, seed/product add, saturate or wrap, overflow flag.
module end_acc_lane #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     load_i,
    input  logic                     add_i,
    input  logic                     capture_i,
    input  logic                     sat_i,
    input  logic signed [DWIDTH-1:0] sum_i,
    input  logic signed [DWIDTH-1:0] prod_i,
    output logic        [DWIDTH-1:0] res_o,
    output logic                     ovf_o
);

    localparam int unsigned AW = DWIDTH + LEN_W + 1;
    localparam logic signed [AW-1:0] MaxV = {{(AW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MinV = {{(AW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    logic signed [AW-1:0] acc_q, acc_d, sum_ext, prod_ext;
    logic        [DWIDTH-1:0] res_q, res_d;
    logic                     ovf_q, ovf_d, ovf_hi, ovf_lo;

    assign sum_ext  = {{(AW-DWIDTH){sum_i[DWIDTH-1]}}, sum_i};
    assign prod_ext = {{(AW-DWIDTH){prod_i[DWIDTH-1]}}, prod_i};

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = sum_ext + prod_ext;
        end else if (add_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    // The result is formed from the value that includes the current (last) beat.
    always_comb begin
        ovf_hi = (acc_d > MaxV);
        ovf_lo = (acc_d < MinV);
        ovf_d  = ovf_hi || ovf_lo;
        res_d  = acc_d[DWIDTH-1:0];
        if (sat_i && ovf_hi) begin
            res_d = MaxV[DWIDTH-1:0];
        end else if (sat_i && ovf_lo) begin
            res_d = MinV[DWIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (capture_i) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign res_o = res_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/end_accumulator.sv
// Multi-lane end accumulator: sums a burst of beats per lane and presents one result per burst.
module end_accumulator
    import end_accumulator_pkg::*;
#(
    parameter int unsigned DWIDTH = DefDwidth,
    parameter int unsigned LANES  = DefLanes,
    parameter int unsigned LEN_W  = DefLenW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    sat_en,
    input  logic                    abort,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DWIDTH-1:0] sum_in,
    input  logic [LANES*DWIDTH-1:0] prod_in,
    output logic [LANES*DWIDTH-1:0] sum_out,
    output logic [LANES-1:0]        ovf_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    acc_state_e       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, eff_len;
    logic [LEN_W:0]   cnt_inc;
    logic             sat_q, sat_d, out_valid_q, out_valid_d;
    logic             accept, first, acc_beat, last, sat_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        accept   = in_valid && in_ready && !abort;
        first    = accept && (state_q == StIdle);
        acc_beat = accept && (state_q == StAcc);
        eff_len  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        cnt_inc  = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};
        last     = (first && (eff_len == LEN_W'(1))) ||
                   (acc_beat && (cnt_inc == {1'b0, len_q}));

        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;

        if (last) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (first) begin
            len_d   = eff_len;
            sat_d   = sat_en;
            state_d = last ? StIdle : StAcc;
            cnt_d   = last ? '0 : LEN_W'(1);
        end else if (acc_beat) begin
            state_d = last ? StIdle : StAcc;
            cnt_d   = last ? '0 : cnt_inc[LEN_W-1:0];
        end
    end

    always_comb begin
        in_ready  = !(out_valid_q && !out_ready);
        out_valid = out_valid_q;
        // A single-beat burst never latches, so the live sat_en applies in IDLE.
        sat_eff   = (state_q == StIdle) ? sat_en : sat_q;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        end_acc_lane #(
            .DWIDTH(DWIDTH),
            .LEN_W (LEN_W)
        ) u_lane (
            .clk_i    (clk),
            .rst_i    (rst),
            .clear_i  (abort),
            .load_i   (first),
            .add_i    (acc_beat),
            .capture_i(last),
            .sat_i    (sat_eff),
            .sum_i    (sum_in[g*DWIDTH +: DWIDTH]),
            .prod_i   (prod_in[g*DWIDTH +: DWIDTH]),
            .res_o    (sum_out[g*DWIDTH +: DWIDTH]),
            .ovf_o    (ovf_out[g])
        );
    end

endmodule
